// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite layer: animation state encoding,
// screen geometry and coordinate widths.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } anim_state_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned EXT_W    = 11;

  // $clog2 clamped to 1 so single-entry ranges still get a 1-bit register
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Animation sequencer: counts frame_start pulses per frame, steps through the
// stored frames, loops or stops on the last one, and flags one-shot completion.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned FRAMES     = 4,
  parameter int unsigned FRAME_HOLD = 8,
  parameter int unsigned LOOP       = 1,
  parameter int unsigned FW         = 2
) (
  input  logic          vga_clk,
  input  logic          Reset,
  input  logic          frame_start,
  input  logic          anim_start,
  input  logic          anim_stop,
  output logic [FW-1:0] anim_frame,
  output logic          anim_done
);

  localparam int unsigned HW = clog2_min1(FRAME_HOLD);

  anim_state_t   r_state;
  logic [HW-1:0] r_hold;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      anim_frame <= '0;
      anim_done  <= 1'b0;
    end else if (anim_start) begin
      // restart beats a coincident frame_start or anim_stop
      r_state    <= PLAY;
      r_hold     <= '0;
      anim_frame <= '0;
      anim_done  <= 1'b0;
    end else begin
      case (r_state)
        PLAY: begin
          if (anim_stop) begin
            r_state <= IDLE;
          end else if (frame_start) begin
            if (r_hold == HW'(FRAME_HOLD - 1)) begin
              r_hold <= '0;
              if (anim_frame != FW'(FRAMES - 1)) begin
                anim_frame <= anim_frame + FW'(1);
              end else if (LOOP != 0) begin
                anim_frame <= '0;
              end else begin
                r_state   <= DONE;
                anim_done <= 1'b1;
              end
            end else begin
              r_hold <= r_hold + HW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sprite_renderer.sv
// Positioned, scaled, animated sprite layer with a fixed 3-cycle pixel pipeline.
// Optional SPRITE_FLIP_EN adds a horizontal-mirror input latched with the position.
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W      = 68,
  parameter int unsigned SPR_H      = 64,
  parameter int unsigned FRAMES     = 4,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter int unsigned FRAME_HOLD = 8,
  parameter int unsigned LOOP       = 1,
  parameter int unsigned TRANSP_IDX = 0,
  parameter int unsigned ADDR_W     = $clog2(SPR_W * SPR_H * FRAMES),
  parameter int unsigned FW         = clog2_min1(FRAMES)
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              pos_load,
  input  logic              anim_start,
  input  logic              anim_stop,
`ifdef SPRITE_FLIP_EN
  input  logic              flip_x,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              pix_hit,
  output logic [FW-1:0]     anim_frame,
  output logic              anim_done
);

  localparam int unsigned CW = clog2_min1(SPR_W);
  localparam int unsigned RW = clog2_min1(SPR_H);
  localparam logic [EXT_W-1:0] BOX_W = EXT_W'(SPR_W << SCALE_LOG2);
  localparam logic [EXT_W-1:0] BOX_H = EXT_W'(SPR_H << SCALE_LOG2);

  logic [COORD_W-1:0] r_sh_x, r_sh_y, r_act_x, r_act_y;
  logic               r_v1, r_v2;
  logic               w_flip;
  logic               w_in_box;
  logic [EXT_W-1:0]   w_dx, w_dy;
  logic [CW-1:0]      w_col;
  logic [RW-1:0]      w_row;
  logic [ADDR_W-1:0]  w_addr;

  sprite_anim_ctrl #(
    .FRAMES     (FRAMES),
    .FRAME_HOLD (FRAME_HOLD),
    .LOOP       (LOOP),
    .FW         (FW)
  ) u_anim (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .anim_start  (anim_start),
    .anim_stop   (anim_stop),
    .anim_frame  (anim_frame),
    .anim_done   (anim_done)
  );

  // Shadow/active pair keeps the position stable for a whole frame
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_sh_x  <= '0;
      r_sh_y  <= '0;
      r_act_x <= '0;
      r_act_y <= '0;
    end else begin
      if (pos_load) begin
        r_sh_x <= pos_x;
        r_sh_y <= pos_y;
      end
      if (frame_start) begin
        r_act_x <= pos_load ? pos_x : r_sh_x;
        r_act_y <= pos_load ? pos_y : r_sh_y;
      end
    end
  end

`ifdef SPRITE_FLIP_EN
  logic r_sh_flip, r_act_flip;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_sh_flip  <= 1'b0;
      r_act_flip <= 1'b0;
    end else begin
      if (pos_load) r_sh_flip <= flip_x;
      if (frame_start) r_act_flip <= pos_load ? flip_x : r_sh_flip;
    end
  end

  assign w_flip = r_act_flip;
`else
  assign w_flip = 1'b0;
`endif

  // 11-bit compares so a box hanging past the right/bottom edge clips instead of wrapping
  always_comb begin
    w_dx     = {1'b0, DrawX} - {1'b0, r_act_x};
    w_dy     = {1'b0, DrawY} - {1'b0, r_act_y};
    w_in_box = ({1'b0, DrawX} >= {1'b0, r_act_x}) &&
               ({1'b0, DrawX} <  ({1'b0, r_act_x} + BOX_W)) &&
               ({1'b0, DrawY} >= {1'b0, r_act_y}) &&
               ({1'b0, DrawY} <  ({1'b0, r_act_y} + BOX_H)) &&
               (DrawX < COORD_W'(SCREEN_W)) && (DrawY < COORD_W'(SCREEN_H));
    w_col    = CW'(w_dx >> SCALE_LOG2);
    if (w_flip) w_col = CW'(SPR_W - 1) - w_col;
    w_row    = RW'(w_dy >> SCALE_LOG2);
    w_addr   = ADDR_W'(anim_frame) * ADDR_W'(SPR_W * SPR_H) +
               ADDR_W'(w_row) * ADDR_W'(SPR_W) + ADDR_W'(w_col);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom_addr <= '0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      pix_idx  <= '0;
      pix_hit  <= 1'b0;
    end else begin
      if (w_in_box) rom_addr <= w_addr;
      r_v1    <= w_in_box & blank;
      r_v2    <= r_v1;
      pix_idx <= r_v2 ? rom_q : '0;
      pix_hit <= r_v2 && (rom_q != IDX_W'(TRANSP_IDX));
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: two configurations against a frame/pixel model
// built from box geometry and frame_start counting, plus literal checkpoints.
module tb_sprite_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  dx = '0, dy = '0;
  logic        blank = 1'b0, fs = 1'b0, ast = 1'b0, astop = 1'b0;
  logic [9:0]  px [2];
  logic [9:0]  py [2];
  logic        pl [2];
  logic [14:0] raddr [2];
  logic [3:0]  rq [2];
  logic [3:0]  pidx [2];
  logic        phit [2];
  logic [1:0]  afr [2];
  logic        adone [2];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sprite_renderer #(.SCALE_LOG2(0), .FRAME_HOLD(2), .LOOP(0)) dut0 (
    .vga_clk(clk), .Reset(rst), .DrawX(dx), .DrawY(dy), .blank(blank),
    .frame_start(fs), .pos_x(px[0]), .pos_y(py[0]), .pos_load(pl[0]),
    .anim_start(ast), .anim_stop(astop),
`ifdef SPRITE_FLIP_EN
    .flip_x(1'b0),
`endif
    .rom_addr(raddr[0]), .rom_q(rq[0]), .pix_idx(pidx[0]), .pix_hit(phit[0]),
    .anim_frame(afr[0]), .anim_done(adone[0])
  );

  sprite_renderer #(.SCALE_LOG2(1), .FRAME_HOLD(3), .LOOP(1)) dut1 (
    .vga_clk(clk), .Reset(rst), .DrawX(dx), .DrawY(dy), .blank(blank),
    .frame_start(fs), .pos_x(px[1]), .pos_y(py[1]), .pos_load(pl[1]),
    .anim_start(ast), .anim_stop(astop),
`ifdef SPRITE_FLIP_EN
    .flip_x(1'b0),
`endif
    .rom_addr(raddr[1]), .rom_q(rq[1]), .pix_idx(pidx[1]), .pix_hit(phit[1]),
    .anim_frame(afr[1]), .anim_done(adone[1])
  );

  // Sprite ROM contents: every address congruent to 2 mod 5 is transparent
  function automatic logic [3:0] romf(input int a);
    if (a % 5 == 2) return 4'd0;
    return 4'((a * 3 + 1) & 15);
  endfunction

  always @(posedge clk) begin
    rq[0] <= romf(int'(raddr[0]));
    rq[1] <= romf(int'(raddr[1]));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_scale [2] = '{0, 1};
  int m_hold  [2] = '{2, 3};
  int m_loop  [2] = '{0, 1};
  int sh_x [2], sh_y [2], ac_x [2], ac_y [2];
  int k [2];
  bit playing [2];
  int e_addr [2];
  bit hv [2][3];
  int hi [2][3];

  function automatic int frame_of(input int kk, input int fh, input int lp);
    int f;
    f = kk / fh;
    if (lp != 0) return f % 4;
    return (f > 3) ? 3 : f;
  endfunction

  always @(posedge clk) begin
    int x, y, fr, bw, bh, addr;
    bit ib;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        sh_x[i] = 0; sh_y[i] = 0; ac_x[i] = 0; ac_y[i] = 0;
        k[i] = 0; playing[i] = 0; e_addr[i] = 0;
        for (int j = 0; j < 3; j++) begin hv[i][j] = 0; hi[i][j] = 0; end
      end else begin
        x  = int'(dx);
        y  = int'(dy);
        fr = frame_of(k[i], m_hold[i], m_loop[i]);
        bw = 68 << m_scale[i];
        bh = 64 << m_scale[i];
        ib = (x < 640) && (y < 480) && (x >= ac_x[i]) && (x < ac_x[i] + bw) &&
             (y >= ac_y[i]) && (y < ac_y[i] + bh);
        addr = fr * 68 * 64 + ((y - ac_y[i]) >> m_scale[i]) * 68 + ((x - ac_x[i]) >> m_scale[i]);
        hv[i][2] = hv[i][1]; hi[i][2] = hi[i][1];
        hv[i][1] = hv[i][0]; hi[i][1] = hi[i][0];
        hv[i][0] = ib && blank;
        hi[i][0] = ib ? int'(romf(addr)) : 0;
        if (ib) e_addr[i] = addr;
        if (fs) begin
          ac_x[i] = pl[i] ? int'(px[i]) : sh_x[i];
          ac_y[i] = pl[i] ? int'(py[i]) : sh_y[i];
        end
        if (pl[i]) begin sh_x[i] = int'(px[i]); sh_y[i] = int'(py[i]); end
        if (ast) begin k[i] = 0; playing[i] = 1; end
        else if (astop) playing[i] = 0;
        else if (fs && playing[i]) k[i]++;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rom_addr[%0d]", i), 32'(raddr[i]), 32'(e_addr[i]));
      chk($sformatf("pix_hit[%0d]", i), 32'(phit[i]), 32'(hv[i][2] && hi[i][2] != 0));
      chk($sformatf("pix_idx[%0d]", i), 32'(pidx[i]), 32'(hv[i][2] ? hi[i][2] : 0));
      chk($sformatf("anim_frame[%0d]", i), 32'(afr[i]), 32'(frame_of(k[i], m_hold[i], m_loop[i])));
      chk($sformatf("anim_done[%0d]", i), 32'(adone[i]),
          32'(m_loop[i] == 0 && k[i] >= m_hold[i] * 4));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int x, input int y, input bit b, input bit f,
                       input bit l0, input bit l1, input bit a, input bit s);
    @(negedge clk);
    dx = 10'(x); dy = 10'(y); blank = b; fs = f;
    pl[0] = l0; pl[1] = l1; ast = a; astop = s;
  endtask

  task automatic after(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    int seq [8] = '{0, 1, 1, 2, 2, 3, 3, 3};
    int t, off;
    px[0] = '0; py[0] = '0; px[1] = '0; py[1] = '0; pl[0] = 1'b0; pl[1] = 1'b0;

    after(2);
    chk("rst_addr", 32'(raddr[0]), 0);
    chk("rst_hit", 32'(phit[0]), 0);
    chk("rst_frame", 32'(afr[0]), 0);
    chk("rst_done", 32'(adone[0]), 0);
    @(negedge clk); rst = 1'b0;

    // load both positions and activate in the same cycle
    px[0] = 10'd100; py[0] = 10'd50; px[1] = 10'd0; py[1] = 10'd0;
    drive(0, 0, 0, 1, 1, 1, 0, 0);
    drive(100, 50, 1, 0, 0, 0, 0, 0);
    after(1); chk("origin_addr", 32'(raddr[0]), 0);
    after(2); chk("origin_hit", 32'(phit[0]), 1); chk("origin_idx", 32'(pidx[0]), 1);
    drive(167, 113, 1, 0, 0, 0, 0, 0);
    after(1); chk("corner_addr", 32'(raddr[0]), 4351);
    drive(168, 113, 1, 0, 0, 0, 0, 0);
    after(3); chk("right_edge_hit", 32'(phit[0]), 0);
    chk("addr_hold", 32'(raddr[0]), 4351);

    drive(3, 5, 1, 0, 0, 0, 0, 0);
    after(1); chk("scaled_addr", 32'(raddr[1]), 137);
    after(2); chk("transp_hit", 32'(phit[1]), 0); chk("transp_idx", 32'(pidx[1]), 0);

    // box hanging off the bottom-right corner
    px[0] = 10'd600; py[0] = 10'd450;
    drive(0, 0, 0, 1, 1, 0, 0, 0);
    drive(639, 479, 1, 0, 0, 0, 0, 0);
    after(1); chk("clip_addr", 32'(raddr[0]), 2011);
    after(2); chk("clip_hit", 32'(phit[0]), 1); chk("clip_idx", 32'(pidx[0]), 2);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    after(3); chk("nowrap_00", 32'(phit[0]), 0);
    drive(39, 33, 1, 0, 0, 0, 0, 0);
    after(3); chk("nowrap_39_33", 32'(phit[0]), 0);
    drive(620, 10, 1, 0, 0, 0, 0, 0);
    after(3); chk("nowrap_y", 32'(phit[0]), 0);

    // mid-frame load must not move the sprite until frame_start
    px[0] = 10'd200; py[0] = 10'd200;
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(600, 450, 1, 0, 0, 0, 0, 0);
    after(1); chk("no_tear_addr", 32'(raddr[0]), 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(201, 200, 1, 0, 0, 0, 0, 0);
    after(1); chk("new_pos_addr", 32'(raddr[0]), 1);

    // one-shot animation with two frame_starts per frame
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      after(1);
      chk($sformatf("oneshot_frame%0d", i), 32'(afr[0]), 32'(seq[i]));
      chk($sformatf("oneshot_done%0d", i), 32'(adone[0]), 32'(i == 7));
      drive(0, 0, 0, 0, 0, 0, 0, 0);
    end

    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst   = ($urandom % 500) == 0;
      fs    = ($urandom % 40) == 0;
      ast   = ($urandom % 300) == 0;
      astop = ($urandom % 400) == 0;
      blank = ($urandom % 8) != 0;
      for (int i = 0; i < 2; i++) begin
        pl[i] = ($urandom % 25) == 0;
        if (pl[i]) begin
          px[i] = 10'($urandom_range(0, 700));
          py[i] = 10'($urandom_range(0, 520));
        end
      end
      t = $urandom % 3;
      if (t == 0) begin
        dx = 10'($urandom_range(0, 639));
        dy = 10'($urandom_range(0, 479));
      end else begin
        off = $urandom_range(0, 300);
        dx = 10'((int'(px[t-1]) + off - 20 + 640) % 640);
        off = $urandom_range(0, 280);
        dy = 10'((int'(py[t-1]) + off - 20 + 480) % 480);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    after(5);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
